fifo_wr_ptr_ctrl: RTL and testbench

//  Write-side pointer/status controller for the dual-clock FIFO, running entirely in the write domain.

---
 rtl/fifo_wr_ptr_ctrl_if.sv | 23 ++
 rtl/fifo_wr_ptr_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-port bundle of the dual-clock FIFO write-side controller.
// The producer drives wr_en and receives acceptance, the RAM address and the status flags.
interface fifo_wr_ptr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  full;
    logic                  prog_full;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  overflow;

    modport master (
        output wr_en,
        input  wr_accept, wr_addr, full, prog_full, wr_count, overflow
    );

    modport slave (
        input  wr_en,
        output wr_accept, wr_addr, full, prog_full, wr_count, overflow
    );
endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer/status controller of the dual-clock FIFO: binary and Gray write
// pointer, read-pointer synchronizer, and full / prog_full / fill count / overflow flags.
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_WIDTH       = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int PROG_FULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   rd_gray_async,
    output logic [ADDR_WIDTH:0]   wr_gray,
    fifo_wr_ptr_ctrl_if.slave     wr_if
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0] sync_d [SYNC_STAGES];

    logic [ADDR_WIDTH:0] wbin_q,  wbin_d;
    logic [ADDR_WIDTH:0] wgray_q, wgray_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q,  full_d;
    logic                prog_full_q, prog_full_d;
    logic                overflow_q,  overflow_d;
    logic [ADDR_WIDTH:0] rgray_s;
    logic [ADDR_WIDTH:0] rbin_s;
    logic                accept_s;

    // Plain shift chain for the read pointer; no logic between stages.
    always_comb begin
        sync_d[0] = rd_gray_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {PW{1'b0}};
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // Next pointer and status; rst_n gates acceptance so the RAM never writes during reset.
    always_comb begin
        rgray_s     = sync_q[SYNC_STAGES-1];
        rbin_s      = gray2bin(rgray_s);
        accept_s    = wr_if.wr_en & ~full_q & rst_n;
        wbin_d      = wbin_q + {{ADDR_WIDTH{1'b0}}, accept_s};
        wgray_d     = bin2gray(wbin_d);
        count_d     = wbin_d - rbin_s;
        full_d      = (count_d == PW'(DEPTH));
        prog_full_d = (count_d >= PW'(PROG_FULL_THRESH));
        overflow_d  = wr_if.wr_en & full_q;
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q      <= {PW{1'b0}};
            wgray_q     <= {PW{1'b0}};
            count_q     <= {PW{1'b0}};
            full_q      <= 1'b0;
            prog_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wgray_q     <= wgray_d;
            count_q     <= count_d;
            full_q      <= full_d;
            prog_full_q <= prog_full_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_gray         = wgray_q;
    assign wr_if.wr_accept = accept_s;
    assign wr_if.wr_addr   = wbin_q[ADDR_WIDTH-1:0];
    assign wr_if.full      = full_q;
    assign wr_if.prog_full = prog_full_q;
    assign wr_if.wr_count  = count_q;
    assign wr_if.overflow  = overflow_q;
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl (DEPTH=16, two sync stages, prog_full at 12):
// a vector table for fill/overflow/drain, plus hand-written reset and wrap sequences.
module tb_fifo_wr_ptr_ctrl;
    localparam int AW = 4;

    typedef struct {
        logic       wr_en;
        logic [4:0] rd_gray;
        logic       exp_accept;
        logic [3:0] exp_addr;
        logic [4:0] exp_gray;
        logic       exp_full;
        logic       exp_pf;
        logic [4:0] exp_count;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rd_gray_async = 5'd0;
    logic [4:0] wr_gray;
    logic [4:0] prev_gray;
    int         checks = 0;
    int         failures = 0;
    vec_t       vecs [24];

    fifo_wr_ptr_ctrl_if #(.ADDR_WIDTH(AW)) wr_if ();

    fifo_wr_ptr_ctrl #(
        .ADDR_WIDTH(AW),
        .SYNC_STAGES(2),
        .PROG_FULL_THRESH(12)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_gray_async (rd_gray_async),
        .wr_gray       (wr_gray),
        .wr_if         (wr_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".accept"},    32'(wr_if.wr_accept), 32'(v.exp_accept));
        check({tag, ".addr"},      32'(wr_if.wr_addr),   32'(v.exp_addr));
        check({tag, ".gray"},      32'(wr_gray),         32'(v.exp_gray));
        check({tag, ".full"},      32'(wr_if.full),      32'(v.exp_full));
        check({tag, ".prog_full"}, 32'(wr_if.prog_full), 32'(v.exp_pf));
        check({tag, ".count"},     32'(wr_if.wr_count),  32'(v.exp_count));
        check({tag, ".overflow"},  32'(wr_if.overflow),  32'(v.exp_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_if.wr_en = 1'b0;
        rd_gray_async = 5'd0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t zero_v;
        zero_v = '{1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0};

        // Fill: 16 accepted writes, read pointer parked at 0
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 5'd0, 1'b1, 4'(i), gray5(i), 1'b0, (i >= 12), 5'(i), 1'b0};
        end
        // Full: two refused writes, then the read pointer jumps to 4
        vecs[16] = '{1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
        vecs[17] = '{1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
        vecs[18] = '{1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
        vecs[19] = '{1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
        vecs[20] = '{1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
        vecs[21] = '{1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd12, 1'b0};
        vecs[22] = '{1'b1, 5'b00110, 1'b1, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd12, 1'b0};
        vecs[23] = '{1'b0, 5'b00110, 1'b0, 4'd1, 5'b11001, 1'b0, 1'b1, 5'd13, 1'b0};

        // Reset held 3 clocks with wr_en high
        wr_if.wr_en = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            check_all("reset", zero_v);
            step();
        end
        rst_n = 1'b1;

        // Table: fill, overflow, drain
        for (int i = 0; i < 24; i++) begin
            wr_if.wr_en = vecs[i].wr_en;
            rd_gray_async = vecs[i].rd_gray;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
            step();
        end

        // Wrap: reader keeps synced pointer three behind the writer
        do_reset();
        prev_gray = 5'd0;
        for (int t = -6; t < 40; t++) begin
            int r;
            r = (t < -3) ? -3 : t;
            wr_if.wr_en = (t >= 0);
            rd_gray_async = gray5(r & 31);
            #1;
            if (t >= -2) check($sformatf("wrap%0d.count", t), 32'(wr_if.wr_count), 32'd3);
            if (t >= 0) begin
                check($sformatf("wrap%0d.accept", t), 32'(wr_if.wr_accept), 32'd1);
                check($sformatf("wrap%0d.full", t),   32'(wr_if.full),      32'd0);
                check($sformatf("wrap%0d.gray", t),   32'(wr_gray),         32'(gray5(t & 31)));
                if (t > 0) begin
                    check($sformatf("wrap%0d.onebit", t), 32'($countones(wr_gray ^ prev_gray)), 32'd1);
                end
                prev_gray = wr_gray;
            end
            step();
        end

        // Async reset after 7 writes, asserted between clock edges
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr_if.wr_en = 1'b1;
            step();
        end
        wr_if.wr_en = 1'b1;
        #1;
        check("pre_rst.addr",  32'(wr_if.wr_addr),  32'd7);
        check("pre_rst.count", 32'(wr_if.wr_count), 32'd7);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", zero_v);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_if.wr_en = 1'b1;
            #1;
            check($sformatf("refill%0d.accept", i), 32'(wr_if.wr_accept), 32'd1);
            check($sformatf("refill%0d.addr", i),   32'(wr_if.wr_addr),   32'(i));
            check($sformatf("refill%0d.count", i),  32'(wr_if.wr_count),  32'(i));
            check($sformatf("refill%0d.gray", i),   32'(wr_gray),         32'(gray5(i)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
